// File: rtl/blackjack_pkg.sv
// Shared types and default constants for the BlackJack interval timer.
package blackjack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int CLK_HZ_DEFAULT  = 50_000_000;
  localparam int TICK_HZ_DEFAULT = 2_000;
  localparam int TWO_SEC_TICKS   = 4_000;

endpackage

// File: rtl/blackjack_timer_tick_prescaler.sv
// Divide-by-DIV clock-enable generator with synchronous clear and freeze.
module tick_prescaler #(
  parameter int DIV = 25_000
) (
  input  logic clk_50M,
  input  logic i_Reset,
  input  logic i_Clear,
  input  logic i_Freeze,
  output logic o_Tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_Div_q, r_Div_d;

  always_comb begin
    r_Div_d = r_Div_q;
    if (i_Clear)
      r_Div_d = '0;
    else if (!i_Freeze)
      r_Div_d = (r_Div_q == LAST) ? '0 : r_Div_q + 1'b1;
  end

  always_ff @(posedge clk_50M) begin
    if (i_Reset) r_Div_q <= '0;
    else         r_Div_q <= r_Div_d;
  end

  // A frozen counter parked on LAST must not re-strobe every cycle.
  assign o_Tick = (r_Div_q == LAST) && !i_Freeze;

endmodule

// File: rtl/blackjack_timer.sv
// Interval timer: 2 kHz enable strobe plus a start/pause/abort down-counter
// that fires a one-cycle event when the interval expires.
module blackjack_timer
  import blackjack_pkg::*;
#(
  parameter int CLK_HZ      = CLK_HZ_DEFAULT,
  parameter int TICK_HZ     = TICK_HZ_DEFAULT,
  parameter int DELAY_TICKS = TWO_SEC_TICKS,
  parameter int WIDTH       = 12
) (
  input  logic             clk_50M,
  input  logic             i_Reset,
  input  logic             i_Start,
  input  logic             i_Pause,
  input  logic             i_Abort,
  output logic             o_Tick2K,
  output logic             o_TwoSec,
  output logic             o_Busy,
  output logic             o_Done,
  output logic [WIDTH-1:0] o_Remaining
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam logic [WIDTH-1:0] LOAD = WIDTH'(DELAY_TICKS);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             two_q, two_d;
  logic             tick, freeze, start_acc;

  assign start_acc = i_Start && !i_Abort;
  assign freeze    = (state_q == ST_PAUSE);

  tick_prescaler #(.DIV(DIV)) u_presc (
    .clk_50M  (clk_50M),
    .i_Reset  (i_Reset),
    .i_Clear  (start_acc),
    .i_Freeze (freeze),
    .o_Tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    two_d   = 1'b0;
    if (i_Abort) begin
      state_d = ST_IDLE;
      rem_d   = '0;
    end else if (i_Start) begin
      state_d = ST_RUN;
      rem_d   = LOAD;
    end else begin
      case (state_q)
        ST_RUN: begin
          // Pause takes precedence over a coincident tick.
          if (i_Pause) begin
            state_d = ST_PAUSE;
          end else if (tick && rem_q != '0) begin
            if (rem_q == ONE) begin
              rem_d   = '0;
              state_d = ST_DONE;
              two_d   = 1'b1;
            end else begin
              rem_d = rem_q - 1'b1;
            end
          end
        end
        ST_PAUSE: if (!i_Pause) state_d = ST_RUN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      two_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      two_q   <= two_d;
    end
  end

  assign o_Tick2K    = tick;
  assign o_TwoSec    = two_q;
  assign o_Busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign o_Done      = (state_q == ST_DONE);
  assign o_Remaining = rem_q;

endmodule

// File: tb/tb_blackjack_timer.sv
// Scoreboard bench: expected strobe cycles and status snapshots are queued per
// scenario and consumed as the DUT produces them.
module tb_blackjack_timer;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst = 1'b0, start = 1'b0, pause = 1'b0, abrt = 1'b0;
  logic         tick2k, twosec, busy, done;
  logic [W-1:0] rem;

  typedef struct {
    int cyc;
    int rem;
    int busy;
    int done;
  } snap_t;

  int    tick_q[$];
  int    two_q[$];
  snap_t snap_q[$];
  int    n_chk = 0;
  int    n_err = 0;

  blackjack_timer #(
    .CLK_HZ(1000), .TICK_HZ(100), .DELAY_TICKS(4), .WIDTH(W)
  ) dut (
    .clk_50M     (clk),
    .i_Reset     (rst),
    .i_Start     (start),
    .i_Pause     (pause),
    .i_Abort     (abrt),
    .o_Tick2K    (tick2k),
    .o_TwoSec    (twosec),
    .o_Busy      (busy),
    .o_Done      (done),
    .o_Remaining (rem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic push_snap(input int c, input int r, input int b, input int d);
    snap_t s;
    s.cyc = c; s.rem = r; s.busy = b; s.done = d;
    snap_q.push_back(s);
  endtask

  task automatic drive(input int sc, input int c);
    rst = 1'b0; start = 1'b0; pause = 1'b0; abrt = 1'b0;
    case (sc)
      1: rst = (c == 0);
      2: start = (c == 0);
      3: begin start = (c == 0); pause = (c >= 15 && c <= 21); end
      4: begin start = (c == 0); abrt = (c == 25); end
      5: start = (c == 0 || c == 30);
      6: begin
        start = (c == 0 || c == 20);
        pause = (c == 20);
        rst   = (c == 20);
      end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; pause = 1'b0; abrt = 1'b0;
  endtask

  task automatic run(input int sc, input int ncyc, input int mon_from);
    snap_t s;
    for (int c = 0; c <= ncyc; c++) begin
      @(negedge clk);
      if (c >= mon_from) begin
        if (tick2k === 1'b1) begin
          if (tick_q.size() == 0) chk($sformatf("s%0d tick_extra", sc), c, -1);
          else                    chk($sformatf("s%0d tick_cyc", sc), c, tick_q.pop_front());
        end
        if (twosec === 1'b1) begin
          if (two_q.size() == 0) chk($sformatf("s%0d twosec_extra", sc), c, -1);
          else                   chk($sformatf("s%0d twosec_cyc", sc), c, two_q.pop_front());
        end
        while (snap_q.size() > 0 && snap_q[0].cyc == c) begin
          s = snap_q.pop_front();
          chk($sformatf("s%0d rem@%0d", sc, c),  int'(rem),  s.rem);
          chk($sformatf("s%0d busy@%0d", sc, c), int'(busy), s.busy);
          chk($sformatf("s%0d done@%0d", sc, c), int'(done), s.done);
        end
      end
      drive(sc, c);
    end
    chk($sformatf("s%0d tick_missing", sc),   tick_q.size(), 0);
    chk($sformatf("s%0d twosec_missing", sc), two_q.size(),  0);
    chk($sformatf("s%0d snap_missing", sc),   snap_q.size(), 0);
    tick_q.delete(); two_q.delete(); snap_q.delete();
  endtask

  initial begin
    // 1: reset then idle; prescaler free-runs
    tick_q = '{10, 20, 30};
    push_snap(1, 0, 0, 0); push_snap(20, 0, 0, 0); push_snap(35, 0, 0, 0);
    run(1, 35, 1);

    // 2: plain interval
    do_reset();
    tick_q = '{10, 20, 30, 40, 50};
    two_q  = '{41};
    push_snap(1, 4, 1, 0);  push_snap(10, 4, 1, 0); push_snap(11, 3, 1, 0);
    push_snap(21, 2, 1, 0); push_snap(31, 1, 1, 0); push_snap(40, 1, 1, 0);
    push_snap(41, 0, 0, 1); push_snap(50, 0, 0, 1);
    run(2, 50, 0);

    // 3: pause for 7 cycles starting at cycle 15
    do_reset();
    tick_q = '{10, 27, 37, 47, 57};
    two_q  = '{48};
    push_snap(16, 3, 1, 0); push_snap(22, 3, 1, 0); push_snap(23, 3, 1, 0);
    push_snap(28, 2, 1, 0); push_snap(47, 1, 1, 0); push_snap(48, 0, 0, 1);
    run(3, 60, 0);

    // 4: abort at cycle 25
    do_reset();
    tick_q = '{10, 20, 30, 40, 50};
    push_snap(25, 2, 1, 0); push_snap(26, 0, 0, 0); push_snap(45, 0, 0, 0);
    run(4, 50, 0);

    // 5: restart at cycle 30 (coincides with a strobe)
    do_reset();
    tick_q = '{10, 20, 30, 40, 50, 60, 70};
    two_q  = '{71};
    push_snap(30, 2, 1, 0); push_snap(31, 4, 1, 0); push_snap(41, 3, 1, 0);
    push_snap(70, 1, 1, 0); push_snap(71, 0, 0, 1);
    run(5, 75, 0);

    // 6: reset mid-interval overriding start and pause
    do_reset();
    tick_q = '{10, 20, 30};
    push_snap(20, 3, 1, 0); push_snap(21, 0, 0, 0); push_snap(25, 0, 0, 0);
    run(6, 35, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
